// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Pipeline sequencing controller for the 5-stage processor. Keeps a per-register
// count of issued-but-unretired writes, decides each cycle whether the decode
// stage may issue its instruction, and holds fetch while a control instruction
// is unresolved. All state changes on the falling edge of I_CLOCK.
//
// Ports:
//   I_CLOCK         clock (state updates on negedge)
//   I_RESET         synchronous active-high reset, sampled at negedge
//   I_LOCK          pipeline enable; low freezes state and zeroes comb outputs
//   I_IssueValid    decode holds a valid instruction
//   I_UseSrc1/2     instruction reads src1/src2
//   I_Src1Idx/2Idx  source register indices
//   I_WritesDest    instruction writes I_DestIdx
//   I_DestIdx       destination register index
//   I_IsCtrl        instruction is a branch/JMP/JSR/JSRR
//   I_CtrlResolved  execute resolved the outstanding control instruction
//   I_WBValid       writeback retires a register write this cycle
//   I_WBDestIdx     register retired
//   O_Issue         instruction accepted this cycle (comb)
//   O_DepStall      data-hazard stall (comb)
//   O_FetchStall    control-hazard stall (from state register)
//   O_Error         sticky: retire to zero count, or stray resolution
//
// Configuration macro:
//   HAZARD_SCOREBOARD_WB_BYPASS_EN - when defined, a source whose only pending
//   writer retires this cycle is not a hazard (register file writes before it
//   is read), saving one stall cycle.
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 2
) (
  input  logic                        I_CLOCK,
  input  logic                        I_RESET,
  input  logic                        I_LOCK,
  input  logic                        I_IssueValid,
  input  logic                        I_UseSrc1,
  input  logic                        I_UseSrc2,
  input  logic [$clog2(NUM_REGS)-1:0] I_Src1Idx,
  input  logic [$clog2(NUM_REGS)-1:0] I_Src2Idx,
  input  logic                        I_WritesDest,
  input  logic [$clog2(NUM_REGS)-1:0] I_DestIdx,
  input  logic                        I_IsCtrl,
  input  logic                        I_CtrlResolved,
  input  logic                        I_WBValid,
  input  logic [$clog2(NUM_REGS)-1:0] I_WBDestIdx,
  output logic                        O_Issue,
  output logic                        O_DepStall,
  output logic                        O_FetchStall,
  output logic                        O_Error
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // BR_WAIT owns its own state bit so the fetch stall decodes from one flop.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_BR_WAIT = 2'b10
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      pend [NUM_REGS];
  logic [NUM_REGS-1:0]   inc_vec, dec_vec;
  logic                  byp1, byp2;
  logic                  hz1, hz2, waw_full, any_hz;
  logic                  issue_ok, ctrl_issue;
  logic                  wb_underflow, bad_resolve;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
`ifdef HAZARD_SCOREBOARD_WB_BYPASS_EN
  assign byp1 = I_WBValid && (I_WBDestIdx == I_Src1Idx) && (pend[I_Src1Idx] == CNT_ONE);
  assign byp2 = I_WBValid && (I_WBDestIdx == I_Src2Idx) && (pend[I_Src2Idx] == CNT_ONE);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign hz1      = I_UseSrc1 && (pend[I_Src1Idx] != '0) && !byp1;
  assign hz2      = I_UseSrc2 && (pend[I_Src2Idx] != '0) && !byp2;
  // A full counter cannot take another writer; hold the WAW producer instead.
  assign waw_full = I_WritesDest && (pend[I_DestIdx] == CNT_MAX);
  assign any_hz   = hz1 || hz2 || waw_full;

  assign issue_ok   = I_LOCK && I_IssueValid && (state == ST_RUN);
  assign O_DepStall = issue_ok && any_hz;
  assign O_Issue    = issue_ok && !any_hz;
  assign ctrl_issue = O_Issue && I_IsCtrl;

  // ---------------------------------------------------------------------------
  // Pending-write counters
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (O_Issue && I_WritesDest) inc_vec[I_DestIdx]   = 1'b1;
    if (I_WBValid)               dec_vec[I_WBDestIdx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      // NOTE: this array is flops, not RAM, so it can be cleared in one cycle.
      for (int r = 0; r < NUM_REGS; r++) pend[r] <= '0;
    end else if (I_LOCK) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        // Issue and retire to the same register cancel; a retire against an
        // empty counter leaves it at zero (flagged below).
        if (inc_vec[r] && !dec_vec[r])
          pend[r] <= pend[r] + CNT_ONE;
        else if (dec_vec[r] && !inc_vec[r] && (pend[r] != '0))
          pend[r] <= pend[r] - CNT_ONE;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error
  // ---------------------------------------------------------------------------
  assign wb_underflow = I_WBValid && (pend[I_WBDestIdx] == '0);
  // A resolution arriving on the very cycle the control instruction issues is
  // ignored rather than treated as stray.
  assign bad_resolve  = I_CtrlResolved && (state != ST_BR_WAIT) && !ctrl_issue;

  always_ff @(negedge I_CLOCK) begin
    if (I_RESET)
      O_Error <= 1'b0;
    else if (I_LOCK && (wb_underflow || bad_resolve))
      O_Error <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(negedge I_CLOCK) begin
    if (I_RESET)
      state <= ST_IDLE;
    else if (I_LOCK)
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    state_nxt = ST_RUN;
      ST_RUN:     if (ctrl_issue)     state_nxt = ST_BR_WAIT;
      ST_BR_WAIT: if (I_CtrlResolved) state_nxt = ST_RUN;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    O_FetchStall = (state == ST_BR_WAIT);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Directed scenarios followed by a randomized run checked against a behavioural
// model of the scoreboard (integer pending counts plus a three-mode controller).
// Inputs change 1 time unit after each falling edge; outputs are sampled on the
// rising edge, half a cycle away from the state-update edge.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_WAIT = 2;

  logic       I_CLOCK = 1'b0;
  logic       I_RESET, I_LOCK, I_IssueValid, I_UseSrc1, I_UseSrc2;
  logic [3:0] I_Src1Idx, I_Src2Idx, I_DestIdx, I_WBDestIdx;
  logic       I_WritesDest, I_IsCtrl, I_CtrlResolved, I_WBValid;
  logic       O_Issue, O_DepStall, O_FetchStall, O_Error;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int   pend_m [16];
  int   mode_m;
  bit   err_m;
  logic exp_issue, exp_dep, exp_fetch, exp_err;

  hazard_scoreboard dut (
    .I_CLOCK        (I_CLOCK),
    .I_RESET        (I_RESET),
    .I_LOCK         (I_LOCK),
    .I_IssueValid   (I_IssueValid),
    .I_UseSrc1      (I_UseSrc1),
    .I_UseSrc2      (I_UseSrc2),
    .I_Src1Idx      (I_Src1Idx),
    .I_Src2Idx      (I_Src2Idx),
    .I_WritesDest   (I_WritesDest),
    .I_DestIdx      (I_DestIdx),
    .I_IsCtrl       (I_IsCtrl),
    .I_CtrlResolved (I_CtrlResolved),
    .I_WBValid      (I_WBValid),
    .I_WBDestIdx    (I_WBDestIdx),
    .O_Issue        (O_Issue),
    .O_DepStall     (O_DepStall),
    .O_FetchStall   (O_FetchStall),
    .O_Error        (O_Error)
  );

  always #5 I_CLOCK = ~I_CLOCK;

  // ---------------------------------------------------------------------------
  // Model
  // ---------------------------------------------------------------------------
  function automatic bit src_hz(bit used, int idx);
    if (!used || pend_m[idx] == 0) return 1'b0;
`ifdef HAZARD_SCOREBOARD_WB_BYPASS_EN
    if (pend_m[idx] == 1 && I_WBValid && int'(I_WBDestIdx) == idx) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic void model_eval();
    bit can;
    can       = I_LOCK && I_IssueValid && (mode_m == M_RUN);
    exp_dep   = can && (src_hz(I_UseSrc1, int'(I_Src1Idx)) || src_hz(I_UseSrc2, int'(I_Src2Idx)) ||
                        (I_WritesDest && pend_m[int'(I_DestIdx)] >= 3));
    exp_issue = can && !exp_dep;
    exp_fetch = (mode_m == M_WAIT);
    exp_err   = err_m;
  endfunction

  function automatic void model_update();
    bit entering;
    if (I_RESET) begin
      foreach (pend_m[r]) pend_m[r] = 0;
      mode_m = M_IDLE;
      err_m  = 1'b0;
      return;
    end
    if (!I_LOCK) return;
    entering = (mode_m == M_RUN) && exp_issue && I_IsCtrl;
    if (I_WBValid && pend_m[int'(I_WBDestIdx)] == 0) err_m = 1'b1;
    if (I_CtrlResolved && mode_m != M_WAIT && !entering) err_m = 1'b1;
    // Increment first, then a decrement that never goes below zero: this gives
    // "same register cancels" and "retire of an empty count stays zero".
    if (exp_issue && I_WritesDest) pend_m[int'(I_DestIdx)]++;
    if (I_WBValid && pend_m[int'(I_WBDestIdx)] > 0) pend_m[int'(I_WBDestIdx)]--;
    case (mode_m)
      M_IDLE:  mode_m = M_RUN;
      M_RUN:   if (entering) mode_m = M_WAIT;
      default: if (I_CtrlResolved) mode_m = M_RUN;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic set_instr(bit v, bit u1, int s1, bit u2, int s2, bit wd, int d, bit ctrl);
    I_IssueValid = v;
    I_UseSrc1    = u1;  I_Src1Idx = 4'(s1);
    I_UseSrc2    = u2;  I_Src2Idx = 4'(s2);
    I_WritesDest = wd;  I_DestIdx = 4'(d);
    I_IsCtrl     = ctrl;
  endtask

  task automatic set_wb(bit v, int idx);
    I_WBValid   = v;
    I_WBDestIdx = 4'(idx);
  endtask

  // Mid-cycle: inputs stable, evaluate expectations.
  task automatic step();
    @(posedge I_CLOCK);
    model_eval();
  endtask

  // Commit the cycle in the model and move past the falling edge.
  task automatic advance();
    model_update();
    @(negedge I_CLOCK);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    I_RESET = 1'b1; I_LOCK = 1'b0; I_CtrlResolved = 1'b0;
    set_instr(1, 0, 0, 0, 0, 1, 1, 0);
    set_wb(0, 0);
    @(negedge I_CLOCK); #1;
    model_update();
    I_LOCK = 1'b1;
    step();
    if ({O_Issue, O_DepStall, O_FetchStall, O_Error} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs: issue/dep/fetch/err=%b expected 0000",
               {O_Issue, O_DepStall, O_FetchStall, O_Error});
    end
    checks++;
    advance();
    I_RESET = 1'b0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    if ({O_Issue, O_FetchStall, O_Error} !== 3'b000) begin
      failures++;
      $display("FAIL idle_cycle: issue/fetch/err=%b expected 000", {O_Issue, O_FetchStall, O_Error});
    end
    checks++;
    advance();
  endtask

  // ADD r3<-r1,r2 then ADDI r4<-r3 waiting on the writeback of r3.
  task automatic test_raw();
    set_instr(1, 1, 1, 1, 2, 1, 3, 0);
    step();
    if ({O_Issue, O_DepStall} !== 2'b10) begin
      failures++;
      $display("FAIL add_issue: issue/dep=%b expected 10", {O_Issue, O_DepStall});
    end
    checks++;
    advance();
    set_instr(1, 1, 3, 0, 0, 1, 4, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      if ({O_Issue, O_DepStall} !== 2'b01) begin
        failures++;
        $display("FAIL raw_stall[%0d]: issue/dep=%b expected 01", k, {O_Issue, O_DepStall});
      end
      checks++;
      advance();
    end
    set_wb(1, 3);
    step();
`ifdef HAZARD_SCOREBOARD_WB_BYPASS_EN
    if (O_Issue !== 1'b1) begin
      failures++;
      $display("FAIL raw_wb_cycle: O_Issue=%b expected 1 (bypass)", O_Issue);
    end
    checks++;
    advance();
    set_wb(0, 0);
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
`else
    if (O_DepStall !== 1'b1) begin
      failures++;
      $display("FAIL raw_wb_cycle: O_DepStall=%b expected 1", O_DepStall);
    end
    checks++;
    advance();
    set_wb(0, 0);
    step();
    if (O_Issue !== 1'b1) begin
      failures++;
      $display("FAIL raw_after_wb: O_Issue=%b expected 1", O_Issue);
    end
    checks++;
    advance();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
`endif
    set_wb(1, 4);   // retire the ADDI
    step(); advance();
    set_wb(0, 0);
  endtask

  task automatic test_branch();
    set_instr(1, 0, 0, 0, 0, 0, 0, 1);   // BRZ
    step();
    if (O_Issue !== 1'b1) begin
      failures++;
      $display("FAIL br_issue: O_Issue=%b expected 1", O_Issue);
    end
    checks++;
    advance();
    set_instr(1, 1, 10, 1, 11, 1, 9, 0); // independent ADD r9 waiting behind it
    for (int k = 0; k < 4; k++) begin
      step();
      if ({O_FetchStall, O_Issue} !== 2'b10) begin
        failures++;
        $display("FAIL br_hold[%0d]: fetch/issue=%b expected 10", k, {O_FetchStall, O_Issue});
      end
      checks++;
      advance();
    end
    I_CtrlResolved = 1'b1;
    step();
    if ({O_FetchStall, O_Issue} !== 2'b10) begin
      failures++;
      $display("FAIL br_resolve_cycle: fetch/issue=%b expected 10", {O_FetchStall, O_Issue});
    end
    checks++;
    advance();
    I_CtrlResolved = 1'b0;
    step();
    if ({O_FetchStall, O_Issue, O_Error} !== 3'b010) begin
      failures++;
      $display("FAIL br_release: fetch/issue/err=%b expected 010", {O_FetchStall, O_Issue, O_Error});
    end
    checks++;
    advance();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(1, 9);
    step(); advance();
    set_wb(0, 0);
    // Resolution coinciding with the branch issue is ignored.
    set_instr(1, 0, 0, 0, 0, 0, 0, 1);
    I_CtrlResolved = 1'b1;
    step(); advance();
    I_CtrlResolved = 1'b0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    if ({O_FetchStall, O_Error} !== 2'b10) begin
      failures++;
      $display("FAIL br_entry_resolve: fetch/err=%b expected 10", {O_FetchStall, O_Error});
    end
    checks++;
    advance();
    I_CtrlResolved = 1'b1;
    step(); advance();
    I_CtrlResolved = 1'b0;
    step();
    if ({O_FetchStall, O_Error} !== 2'b00) begin
      failures++;
      $display("FAIL br_late_resolve: fetch/err=%b expected 00", {O_FetchStall, O_Error});
    end
    checks++;
    advance();
  endtask

  // Issue writing r5 and retire of r5 in one cycle leaves pend[5] at 1.
  task automatic test_same_cycle();
    set_instr(1, 0, 0, 0, 0, 1, 5, 0);
    step(); advance();
    set_wb(1, 5);
    step();
    if (O_Issue !== 1'b1) begin
      failures++;
      $display("FAIL same_issue: O_Issue=%b expected 1", O_Issue);
    end
    checks++;
    advance();
    set_wb(0, 0);
    set_instr(1, 1, 5, 0, 0, 0, 0, 0);   // reader of r5
    step();
    if ({O_DepStall, O_Error} !== 2'b10) begin
      failures++;
      $display("FAIL same_still_pending: dep/err=%b expected 10", {O_DepStall, O_Error});
    end
    checks++;
    advance();
    set_wb(1, 5);
    step();
`ifdef HAZARD_SCOREBOARD_WB_BYPASS_EN
    if (O_Issue !== 1'b1) begin
      failures++;
      $display("FAIL same_count_one: O_Issue=%b expected 1", O_Issue);
    end
    checks++;
    advance();
    set_wb(0, 0);
`else
    advance();
    set_wb(0, 0);
    step();
    if (O_Issue !== 1'b1) begin
      failures++;
      $display("FAIL same_count_one: O_Issue=%b expected 1", O_Issue);
    end
    checks++;
    advance();
`endif
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_saturation();
    set_instr(1, 0, 0, 0, 0, 1, 2, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      if (O_Issue !== 1'b1) begin
        failures++;
        $display("FAIL sat_fill[%0d]: O_Issue=%b expected 1", k, O_Issue);
      end
      checks++;
      advance();
    end
    for (int k = 0; k < 2; k++) begin
      step();
      if ({O_Issue, O_DepStall} !== 2'b01) begin
        failures++;
        $display("FAIL sat_stall[%0d]: issue/dep=%b expected 01", k, {O_Issue, O_DepStall});
      end
      checks++;
      advance();
    end
    set_wb(1, 2);
    step();
    if (O_DepStall !== 1'b1) begin
      failures++;
      $display("FAIL sat_wb_cycle: O_DepStall=%b expected 1", O_DepStall);
    end
    checks++;
    advance();
    set_wb(0, 0);
    step();
    if (O_Issue !== 1'b1) begin
      failures++;
      $display("FAIL sat_release: O_Issue=%b expected 1", O_Issue);
    end
    checks++;
    advance();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(1, 2);
    for (int k = 0; k < 3; k++) begin step(); advance(); end
    set_wb(0, 0);
  endtask

  task automatic test_lock();
    I_LOCK = 1'b0;
    set_instr(1, 0, 0, 0, 0, 0, 0, 0);
    set_wb(1, 8);                        // pend[8]==0, but frozen
    step();
    if ({O_Issue, O_DepStall} !== 2'b00) begin
      failures++;
      $display("FAIL lock_low: issue/dep=%b expected 00", {O_Issue, O_DepStall});
    end
    checks++;
    advance();
    I_LOCK = 1'b1;
    set_wb(0, 0);
    step();
    if ({O_Issue, O_Error} !== 2'b10) begin
      failures++;
      $display("FAIL lock_resume: issue/err=%b expected 10", {O_Issue, O_Error});
    end
    checks++;
    advance();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_error();
    set_wb(1, 7);
    step(); advance();
    set_wb(0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      if (O_Error !== 1'b1) begin
        failures++;
        $display("FAIL err_sticky[%0d]: O_Error=%b expected 1", k, O_Error);
      end
      checks++;
      advance();
    end
    I_RESET = 1'b1;
    step(); advance();
    I_RESET = 1'b0;
    set_instr(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    if ({O_Issue, O_FetchStall, O_Error} !== 3'b000) begin
      failures++;
      $display("FAIL err_reset: issue/fetch/err=%b expected 000", {O_Issue, O_FetchStall, O_Error});
    end
    checks++;
    advance();
    step();
    if (O_Issue !== 1'b1) begin
      failures++;
      $display("FAIL err_reset_run: O_Issue=%b expected 1", O_Issue);
    end
    checks++;
    advance();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random(int cycles);
    int busy [$];
    for (int n = 0; n < cycles; n++) begin
      I_RESET = ($urandom_range(0, 127) == 0);
      I_LOCK  = ($urandom_range(0, 7) != 0);
      set_instr($urandom_range(0, 3) != 0,
                $urandom_range(0, 1), $urandom_range(0, 7),
                $urandom_range(0, 1), $urandom_range(0, 7),
                $urandom_range(0, 2) != 0, $urandom_range(0, 7),
                $urandom_range(0, 5) == 0);
      I_CtrlResolved = (mode_m == M_WAIT) && ($urandom_range(0, 2) == 0);
      busy = {};
      foreach (pend_m[r]) if (pend_m[r] > 0) busy.push_back(r);
      if (busy.size() > 0 && $urandom_range(0, 1) == 1)
        set_wb(1, busy[$urandom_range(0, busy.size() - 1)]);
      else
        set_wb(0, 0);
      step();
      if ({O_Issue, O_DepStall, O_FetchStall, O_Error} !== {exp_issue, exp_dep, exp_fetch, exp_err}) begin
        failures++;
        $display("FAIL random[%0d]: issue/dep/fetch/err=%b expected %b", n,
                 {O_Issue, O_DepStall, O_FetchStall, O_Error}, {exp_issue, exp_dep, exp_fetch, exp_err});
      end
      checks++;
      advance();
    end
    I_RESET = 1'b0;
    I_LOCK  = 1'b1;
    I_CtrlResolved = 1'b0;
    set_wb(0, 0);
    set_instr(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_raw();
    test_branch();
    test_same_cycle();
    test_saturation();
    test_lock();
    test_error();
    test_random(800);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
